// File: rtl/proc_pkg.sv
// Shared processor constants used by the PC and the fetch stage.
//   XLEN       : datapath / instruction width
//   NOP        : instruction word delivered for bubbles and faulting fetches
//   INT_VECTOR : word address the PC redirects to on an interrupt
package proc_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
  localparam int unsigned INT_VECTOR = 16;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC-side request and control, program-loader write port,
// and the fetch/decode boundary plus EPC outputs.
//   master : driven by the PC / control / loader side, observes the boundary
//   slave  : the fetch stage itself
interface fetch_stage_if #(
  parameter int unsigned ADDR_W = 10
);
  import proc_pkg::*;

  logic [XLEN-1:0]   pc_addr;
  logic              halt;
  logic              stall;
  logic              flush;
  logic              int_sig;
  logic              epc_clear;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   instr;
  logic [XLEN-1:0]   instr_pc;
  logic              instr_valid;
  logic              addr_fault;
  logic [XLEN-1:0]   epc;
  logic              epc_valid;
  logic              int_overrun;

  modport master (
    output pc_addr, halt, stall, flush, int_sig, epc_clear,
    output load_we, load_addr, load_data,
    input  instr, instr_pc, instr_valid, addr_fault, epc, epc_valid, int_overrun
  );

  modport slave (
    input  pc_addr, halt, stall, flush, int_sig, epc_clear,
    input  load_we, load_addr, load_data,
    output instr, instr_pc, instr_valid, addr_fault, epc, epc_valid, int_overrun
  );

endinterface

// File: rtl/instr_mem.sv
// Single-clock instruction RAM: one synchronous write port, one synchronous
// read-before-write read port whose output register has an enable and a
// synchronous clear (clear wins, loads NOP).
//   clock            : clock
//   we/wr_addr/wr_data : write port
//   rd_en/rd_clr     : output register enable / clear-to-NOP
//   rd_addr/rd_data  : read port
module instr_mem
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_data
);

  logic [XLEN-1:0] mem [DEPTH];

  // Write port; contents are never reset.
  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read port samples the pre-write contents on a same-index collision.
  always_ff @(posedge clock) begin
    if (rd_clr)     rd_data <= NOP;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: reads the instruction memory at pc_addr and
// registers instruction, address, valid and fault flags into the
// fetch/decode boundary; handles stall/halt hold, flush/interrupt squash and
// EPC capture.
//   clock, reset : clock, synchronous active-high reset
//   bus          : fetch_stage_if.slave (requests, loader, boundary, EPC)
module fetch_stage
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic            clock,
  input  logic            reset,
  fetch_stage_if.slave    bus
);

  if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
    $error("fetch_stage: ADDR_W must equal clog2(DEPTH)");
  end

  logic            fault_c;
  logic            hold_c;
  logic            squash_c;
  logic            rd_en_c;
  logic            rd_clr_c;
  logic [XLEN-1:0] rd_data;

  logic [XLEN-1:0] instr_pc_q;
  logic            instr_valid_q;
  logic            addr_fault_q;
  logic [XLEN-1:0] epc_q;
  logic            epc_valid_q;
  logic            int_overrun_q;

  // Event decode: squash outranks hold; faulting fetches deliver NOP.
  always_comb begin
    fault_c  = bus.pc_addr >= XLEN'(DEPTH);
    hold_c   = bus.halt | bus.stall;
    squash_c = bus.int_sig | bus.flush;
    rd_clr_c = reset | squash_c | (!hold_c & fault_c);
    rd_en_c  = !hold_c & !fault_c;
  end

  // The RAM output register doubles as the boundary's instruction field.
  instr_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_instr_mem (
    .clock   (clock),
    .we      (bus.load_we),
    .wr_addr (bus.load_addr),
    .wr_data (bus.load_data),
    .rd_en   (rd_en_c),
    .rd_clr  (rd_clr_c),
    .rd_addr (bus.pc_addr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // Boundary register: address, valid and fault flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      addr_fault_q  <= 1'b0;
    end else if (squash_c) begin
      instr_pc_q    <= bus.pc_addr;
      instr_valid_q <= 1'b0;
      addr_fault_q  <= 1'b0;
    end else if (!hold_c) begin
      instr_pc_q    <= bus.pc_addr;
      instr_valid_q <= 1'b1;
      addr_fault_q  <= fault_c;
    end
  end

  // EPC: capture on interrupt when free (or being released the same cycle),
  // otherwise flag an overrun for one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      epc_q         <= '0;
      epc_valid_q   <= 1'b0;
      int_overrun_q <= 1'b0;
    end else begin
      int_overrun_q <= 1'b0;
      if (bus.int_sig) begin
        if (!epc_valid_q || bus.epc_clear) begin
          epc_q       <= bus.pc_addr;
          epc_valid_q <= 1'b1;
        end else begin
          int_overrun_q <= 1'b1;
        end
      end else if (bus.epc_clear) begin
        epc_valid_q <= 1'b0;
      end
    end
  end

  assign bus.instr       = rd_data;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.addr_fault  = addr_fault_q;
  assign bus.epc         = epc_q;
  assign bus.epc_valid   = epc_valid_q;
  assign bus.int_overrun = int_overrun_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural model of the fetch boundary
// and EPC is compared against the DUT after every clock edge, and literal
// expectations along the directed sequence pin the model itself.
module tb_fetch_stage;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;

  logic clock;
  logic reset;

  fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_instr, m_pc, m_epc;
  logic        m_valid, m_fault, m_epc_valid, m_ovr;
  bit          m_active = 0;

  // Model advance at each edge, then compare once outputs have settled.
  always @(posedge clock) begin
    int unsigned pc;
    pc = bus.pc_addr;
    if (reset) begin
      m_active = 1;
      m_instr = 0; m_pc = 0; m_valid = 0; m_fault = 0;
      m_epc = 0; m_epc_valid = 0; m_ovr = 0;
    end else begin
      m_ovr = 0;
      if (bus.int_sig || bus.flush) begin
        m_instr = 0; m_valid = 0; m_fault = 0; m_pc = pc;
      end else if (!(bus.halt || bus.stall)) begin
        m_pc = pc; m_valid = 1;
        m_fault = (pc >= DEPTH);
        m_instr = m_fault ? 32'h0 : m_mem[pc % DEPTH];
      end
      if (bus.int_sig) begin
        if (m_epc_valid && !bus.epc_clear) m_ovr = 1;
        else begin m_epc = pc; m_epc_valid = 1; end
      end else if (bus.epc_clear) begin
        m_epc_valid = 0;
      end
    end
    // Loader write lands after the read has taken the old word.
    if (bus.load_we) m_mem[bus.load_addr] = bus.load_data;
    #1;
    if (m_active) begin
      chk("model_instr",       bus.instr,              m_instr);
      chk("model_instr_pc",    bus.instr_pc,           m_pc);
      chk("model_instr_valid", 32'(bus.instr_valid),   32'(m_valid));
      chk("model_addr_fault",  32'(bus.addr_fault),    32'(m_fault));
      chk("model_epc",         bus.epc,                m_epc);
      chk("model_epc_valid",   32'(bus.epc_valid),     32'(m_epc_valid));
      chk("model_int_overrun", 32'(bus.int_overrun),   32'(m_ovr));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic ctl(input logic [31:0] pc, input logic st, input logic hl,
                     input logic fl, input logic it, input logic ec);
    bus.pc_addr = pc; bus.stall = st; bus.halt = hl;
    bus.flush = fl; bus.int_sig = it; bus.epc_clear = ec;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus.load_we = 1'b1; bus.load_addr = a; bus.load_data = d;
    tick();
    bus.load_we = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                            input logic v, input logic f);
    chk({tag, "_instr"},    bus.instr,             ins);
    chk({tag, "_pc"},       bus.instr_pc,          pc);
    chk({tag, "_valid"},    32'(bus.instr_valid),  32'(v));
    chk({tag, "_fault"},    32'(bus.addr_fault),   32'(f));
  endtask

  task automatic expect_epc(input string tag, input logic [31:0] e, input logic ev,
                            input logic ov);
    chk({tag, "_epc"},       bus.epc,              e);
    chk({tag, "_epc_valid"}, 32'(bus.epc_valid),   32'(ev));
    chk({tag, "_overrun"},   32'(bus.int_overrun), 32'(ov));
  endtask

  initial begin
    reset = 1'b1;
    ctl(0, 0, 0, 0, 0, 0);
    bus.load_we = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    @(negedge clock);

    // Program load while reset is held.
    load(0, 32'h11); load(1, 32'h22); load(2, 32'h33); load(3, 32'h44);
    load(4, 32'h55); load(9, 32'h99); load(10'd1023, 32'h77);
    expect_out("reset", 0, 0, 0, 0);
    expect_epc("reset", 0, 0, 0);

    // Sequential fetch.
    reset = 1'b0;
    ctl(0, 0, 0, 0, 0, 0); tick(); expect_out("f0", 32'h11, 0, 1, 0);
    ctl(1, 0, 0, 0, 0, 0); tick(); expect_out("f1", 32'h22, 1, 1, 0);

    // Stall holds for 3 edges, then resumes with the current address.
    for (int i = 0; i < 3; i++) begin
      ctl(2, 1, 0, 0, 0, 0); tick(); expect_out("stall", 32'h22, 1, 1, 0);
    end
    ctl(2, 0, 0, 0, 0, 0); tick(); expect_out("f2", 32'h33, 2, 1, 0);
    ctl(3, 0, 0, 0, 0, 0); tick(); expect_out("f3", 32'h44, 3, 1, 0);

    // Flush wins over a simultaneous stall.
    ctl(2, 1, 0, 1, 0, 0); tick(); expect_out("flush", 0, 2, 0, 0);
    ctl(9, 0, 0, 0, 0, 0); tick(); expect_out("f9", 32'h99, 9, 1, 0);

    // Interrupt capture, then overrun.
    ctl(5, 0, 0, 0, 1, 0);  tick(); expect_out("int1", 0, 5, 0, 0);
    expect_epc("int1", 5, 1, 0);
    ctl(16, 0, 0, 0, 1, 0); tick(); expect_out("int2", 0, 16, 0, 0);
    expect_epc("int2", 5, 1, 1);
    ctl(0, 0, 0, 0, 0, 0);  tick(); expect_out("post_ovr", 32'h11, 0, 1, 0);
    expect_epc("post_ovr", 5, 1, 0);
    ctl(1, 0, 0, 0, 0, 1);  tick(); expect_epc("eclr", 5, 0, 0);

    // Interrupt plus release in the same cycle captures without overrun.
    ctl(3, 0, 0, 0, 1, 0);  tick(); expect_epc("int3", 3, 1, 0);
    ctl(9, 0, 0, 0, 1, 1);  tick(); expect_epc("int_clr", 9, 1, 0);

    // Address range boundary.
    ctl(1024, 0, 0, 0, 0, 0); tick(); expect_out("oob", 0, 1024, 1, 1);
    ctl(1023, 0, 0, 0, 0, 0); tick(); expect_out("last", 32'h77, 1023, 1, 0);

    // Halt holds for 2 edges; first edge after release fetches current pc.
    ctl(2, 0, 0, 0, 0, 0); tick(); expect_out("pre_halt", 32'h33, 2, 1, 0);
    for (int i = 0; i < 2; i++) begin
      ctl(3, 0, 1, 0, 0, 0); tick(); expect_out("halt", 32'h33, 2, 1, 0);
    end
    ctl(3, 0, 0, 0, 0, 0); tick(); expect_out("post_halt", 32'h44, 3, 1, 0);

    // Read-before-write collision.
    ctl(4, 0, 0, 0, 0, 0);
    load(4, 32'hAB);                expect_out("rbw_old", 32'h55, 4, 1, 0);
    ctl(4, 0, 0, 0, 0, 0); tick();  expect_out("rbw_new", 32'hAB, 4, 1, 0);

    // Mid-stream reset drops EPC and the boundary.
    chk("pre_reset_epc_valid", 32'(bus.epc_valid), 32'd1);
    reset = 1'b1; tick();
    expect_out("rst2", 0, 0, 0, 0);
    expect_epc("rst2", 0, 0, 0);
    reset = 1'b0;
    ctl(0, 0, 0, 0, 0, 0); tick(); expect_out("after_rst", 32'h11, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage directly downstream of the program counter. Each cycle it takes the word address driven by the PC, reads the on-chip instruction memory synchronously and registers the result into the fetch/decode boundary as instruction, address and valid flag. It also handles the fetch-side control events:

- stall and halt freeze the boundary register;
- taken branches and jumps squash the fetched word;
- interrupts squash the fetched word and latch the return address (EPC).

## Interface
Parameters:
- DEPTH, 1024, instruction memory size in 32-bit words.
- ADDR_W, 10, memory index width; must equal clog2(DEPTH).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- pc_addr  in  32  word address from the PC (word-addressed, +1 per instruction).
- halt  in  1  processor halted; boundary register holds.
- stall  in  1  downstream not ready; boundary register holds.
- flush  in  1  taken branch/jump this cycle; squash the word being fetched.
- int_sig  in  1  interrupt taken this cycle; PC is redirecting to vector 16.
- epc_clear  in  1  return-from-interrupt; releases EPC.
- load_we  in  1  instruction memory write enable (program loader).
- load_addr  in  ADDR_W  write index.
- load_data  in  32  write data.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address instr was fetched from.
- instr_valid  out  1  instr is a real instruction (not a bubble).
- addr_fault  out  1  instr_pc is outside the memory (pc_addr >= DEPTH).
- epc  out  32  saved return address.
- epc_valid  out  1  EPC holds an unserviced return address.
- int_overrun  out  1  one-cycle pulse: interrupt arrived while epc_valid=1.

## Operation
Event priority per cycle: reset > int_sig > flush > (halt | stall) > normal.

- **Normal:**
  - instr <= mem[pc_addr[ADDR_W-1:0]]; instr_pc <= pc_addr; instr_valid <= 1.
  - addr_fault <= (pc_addr >= DEPTH).
  - A faulting address delivers NOP (32'h0) with instr_valid=1 and addr_fault=1.
- **halt or stall:** instr, instr_pc, instr_valid and addr_fault all hold their values.
- **flush:**
  - instr <= NOP; instr_valid <= 0; instr_pc <= pc_addr; addr_fault <= 0.
  - Applies even when stall or halt is high.
- **int_sig:**
  - Boundary register is loaded exactly as for flush.
  - If epc_valid=0: epc <= pc_addr (the next unexecuted instruction); epc_valid <= 1.
  - If epc_valid=1: epc is unchanged and int_overrun pulses high for one cycle.
- **epc_clear:** epc_valid <= 0 and epc holds its value.
  - If int_sig and epc_clear are high in the same cycle, the capture proceeds: epc <= pc_addr, epc_valid stays 1, and no overrun is signalled.
- **Memory write:** any cycle with load_we=1 writes mem[load_addr] <= load_data.
  - Writes are accepted during reset, halt and stall.
  - When the read index equals load_addr in the same cycle, the read returns the old data (read-before-write).
- **Reset values:** instr=0, instr_pc=0, instr_valid=0, addr_fault=0, epc=0, epc_valid=0, int_overrun=0. Memory contents are not reset.

## Timing
- Fetch latency is 1 cycle: a pc_addr sampled at edge N appears on instr at edge N+1.
- instr_valid rises one cycle after reset deasserts.
- flush and int_sig take effect at the same edge they are sampled. The bubble is visible for exactly one cycle, provided the signal is not held.
- int_overrun is registered. It is high for the single cycle after the colliding edge.
- Holding halt for K cycles keeps every output constant for K cycles. The first edge after halt drops fetches the current pc_addr.
- A reset asserted mid-stream clears all outputs at that edge. EPC is lost even if epc_valid=1.

## Structure
- The shared package proc_pkg holds:
  - XLEN = 32;
  - NOP = 32'h0000_0000;
  - INT_VECTOR = 16, shared with the PC.
- One sub-module, instr_mem: a single-clock RAM with one synchronous write port and one synchronous read-before-write read port, parameterized by DEPTH and ADDR_W.
- fetch_stage contains the boundary register, the address-range check and the EPC logic.

## Test plan
- Load mem[0..3] = 0x11,0x22,0x33,0x44. Release reset, then drive pc_addr 0,1,2,3 → instr 0x11,0x22,0x33,0x44 one cycle later each, with instr_pc 0..3 and instr_valid=1.
- Assert stall for 3 cycles while instr=0x22 → instr=0x22 and instr_pc=1 held for 3 cycles; 0x33 appears on the first edge after stall drops.
- Assert flush with pc_addr=2 → instr=0, instr_valid=0 for one cycle. Then pc_addr=9 with mem[9]=0x99 → instr=0x99, valid=1.
- Assert int_sig with pc_addr=5 → epc=5, epc_valid=1, bubble. A second int_sig with pc_addr=16 → epc stays 5 and int_overrun pulses once. Then epc_clear → epc_valid=0.
- DEPTH=1024, pc_addr=1024 → instr=0, addr_fault=1, instr_valid=1. pc_addr=1023 → addr_fault=0.
- Write load_addr=4, load_data=0xAB in the same cycle pc_addr=4 with old mem[4]=0x55 → instr=0x55. A re-read of address 4 returns 0xAB.
- Assert reset with epc_valid=1 and instr_valid=1 → all outputs 0 at that edge.
